fp_mul_arbiter: RTL

- Shares one multi-cycle floating-point multiplier (Booth-iterative core behind registered operands) among NUM_REQ requesters.
- Picks a requester round-robin, captures its operands and sequences the core: clear, load, fixed iteration wait, then result capture.
- Returns the product, overflow/underflow flags and requester ID over a valid/ready response channel.
- Sits between client pipelines and the fp multiplier; it is the only block that drives the multiplier's reset and load pins.

---
 rtl/fp_mul_ctrl_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/fp_mul_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fp_mul_ctrl_pkg
// Shared types and constants for the fp multiplier arbiter.
//   state_e       : controller states (IDLE, CLR, LOAD, RUN, CAPT, RESP)
//   MUL_LAT_DEF   : default RUN length in cycles after the load strobe
//   CNT_W_DEF     : iteration counter width at the default latency
//   FP_*          : IEEE-754 single-precision field layout
//   cnt_width()   : counter width needed to hold MUL_LAT-1
// ---------------------------------------------------------------------------
package fp_mul_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    CAPT = 3'd4,
    RESP = 3'd5
  } state_e;

  localparam int MUL_LAT_DEF = 27;

  // Width of a counter that runs from lat-1 down to 0.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(MUL_LAT_DEF);

  localparam int FP_W        = 32;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;
  localparam int FP_EXP_BIAS = 127;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at i_ptr and walks
// upward with wrap; the first asserted request wins.
//   i_req   : request vector
//   i_ptr   : index with highest priority this cycle
//   o_grant : one-hot grant (all zero when no request)
//   o_idx   : encoded index of the granted requester
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  // Priority search from the pointer with wrap-around.
  always_comb begin
    int  k;
    logic found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    k       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = (int'(i_ptr) + off) % NUM_REQ;
      if (!found && i_req[k]) begin
        o_grant[k] = 1'b1;
        o_idx      = ID_W'(k);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fp_mul_arbiter
// Shares one multi-cycle fp multiplier among NUM_REQ requesters. A
// round-robin winner's operands are captured, the multiplier is cleared,
// loaded, left to iterate for MUL_LAT cycles, and its result is returned
// on a valid/ready response channel tagged with the requester ID.
//   i_req_valid/i_req_a/i_req_b/o_req_ready : per-requester request side
//   o_mul_rst/o_mul_load/o_mul_a/o_mul_b    : multiplier control/operands
//   i_mul_res/i_mul_overflow/i_mul_underflow: multiplier result
//   o_rsp_*/i_rsp_ready                     : response channel
//   o_busy                                  : controller not in IDLE
// ---------------------------------------------------------------------------
module fp_mul_arbiter
  import fp_mul_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ID_W    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [32*NUM_REQ-1:0]   i_req_a,
  input  logic [32*NUM_REQ-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic                    o_mul_rst,
  output logic                    o_mul_load,
  output logic [31:0]             o_mul_a,
  output logic [31:0]             o_mul_b,
  input  logic [31:0]             i_mul_res,
  input  logic                    i_mul_overflow,
  input  logic                    i_mul_underflow,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [31:0]             o_rsp_res,
  output logic                    o_rsp_overflow,
  output logic                    o_rsp_underflow,
  output logic                    o_busy
);

  localparam int             CNT_W    = cnt_width(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [31:0]        rsp_res_q, rsp_res_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_unf_q, rsp_unf_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant),
    .o_idx   (grant_idx),
    .o_any   (grant_any)
  );

  // Grants are only offered while idle; grant is already gated by valid,
  // so a visible ready bit is a handshake.
  assign o_req_ready = (state_q == IDLE) ? grant : '0;

  // Multiplier reset also follows the block reset so the core is held
  // cleared for every reset cycle.
  assign o_mul_rst  = ~i_rst_n | (state_q == CLR);
  assign o_mul_load = (state_q == LOAD);
  assign o_busy     = (state_q != IDLE);

  assign o_mul_a         = mul_a_q;
  assign o_mul_b         = mul_b_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_id        = rsp_id_q;
  assign o_rsp_res       = rsp_res_q;
  assign o_rsp_overflow  = rsp_ovf_q;
  assign o_rsp_underflow = rsp_unf_q;

  // Next-state and datapath update for the sequencing controller.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_unf_d   = rsp_unf_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          mul_a_d = i_req_a[32*int'(grant_idx) +: 32];
          mul_b_d = i_req_b[32*int'(grant_idx) +: 32];
          id_d    = grant_idx;
          // Winner drops to lowest priority next round.
          if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_idx + ID_W'(1);
          end
          state_d = CLR;
        end else begin
          state_d = IDLE;
        end
      end
      CLR: begin
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = CNT_INIT;
        state_d = RUN;
      end
      RUN: begin
        // Counter starts at MUL_LAT-1, so RUN spans exactly MUL_LAT cycles.
        if (cnt_q == '0) begin
          state_d = CAPT;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = RUN;
        end
      end
      CAPT: begin
        rsp_res_d   = i_mul_res;
        rsp_ovf_d   = i_mul_overflow;
        rsp_unf_d   = i_mul_underflow;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      mul_a_q     <= 32'h0000_0000;
      mul_b_q     <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= 32'h0000_0000;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_unf_q   <= rsp_unf_d;
    end
  end

endmodule
